// File: rtl/f_pkg.sv
// Shared constants for the single-precision multiply back end:
// operand class encoding, exponent limits, canonical quiet NaN and flag bit positions.
package f_pkg;

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int EXP_BITS = 8;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

endpackage

// File: rtl/f_round_ne.sv
// Round-to-nearest-even on a normalized significand plus exponent range check.
// Purely combinational so it can be shared with other arithmetic stages.
module f_round_ne
    import f_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 23,
    parameter int EMAX   = EXP_MAX
) (
    input  logic                    [MANT_W-1:0]   kept_i,
    input  logic                                   g_i,
    input  logic                                   s_i,
    input  logic signed             [EXP_W-1:0]    e_i,
    output logic                    [MANT_W-1:0]   frac_o,
    output logic                    [EXP_BITS-1:0] exp_o,
    output logic                                   ovf_o,
    output logic                                   unf_o,
    output logic                                   inexact_o
);

    localparam logic signed [EXP_W-1:0] E_MAX = EXP_W'(EMAX);
    localparam logic signed [EXP_W-1:0] E_MIN = EXP_W'(1);

    logic                    up;
    logic [MANT_W:0]         sum;
    logic signed [EXP_W-1:0] e_r;

    assign up  = g_i & (s_i | kept_i[0]);
    assign sum = {1'b0, kept_i} + {{MANT_W{1'b0}}, up};

    // An all-ones fraction rounding up wraps to zero; the carry bumps the exponent.
    assign e_r       = e_i + $signed({{(EXP_W-1){1'b0}}, sum[MANT_W]});
    assign frac_o    = sum[MANT_W-1:0];
    assign exp_o     = e_r[EXP_BITS-1:0];
    assign ovf_o     = (e_r >= E_MAX);
    assign unf_o     = (e_r < E_MIN);
    assign inexact_o = g_i | s_i | ovf_o | unf_o;

endmodule

// File: rtl/f_mul_round_norm.sv
// Post-multiply normalize (S1) and round/pack (S2) for single precision,
// two-stage valid/ready pipeline; subnormal results flush to signed zero.
module f_mul_round_norm
    import f_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 23,
    parameter int BIAS   = f_pkg::BIAS
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [EXP_W-1:0]              in_exp,
    input  logic [2*(MANT_W+1)-1:0]       in_mant,
    input  logic [1:0]                    in_class,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out,
    output logic [2:0]                    out_flags
);

    localparam int PW = 2 * (MANT_W + 1);

    logic                    s1_valid_q;
    logic                    s1_sign_q;
    logic [1:0]              s1_class_q;
    logic [MANT_W-1:0]       s1_kept_q, s1_kept_d;
    logic                    s1_g_q, s1_g_d;
    logic                    s1_s_q, s1_s_d;
    logic signed [EXP_W-1:0] s1_e_q, s1_e_d;

    logic                    out_valid_q;
    logic [31:0]             out_q, out_d;
    logic [2:0]              flags_q, flags_d;

    logic s1_adv, s2_adv;

    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // Product of two [1,2) significands lies in [1,4): at most one right shift.
    always_comb begin
        if (in_mant[PW-1]) begin
            s1_kept_d = in_mant[PW-2 -: MANT_W];
            s1_g_d    = in_mant[PW-2-MANT_W];
            s1_s_d    = |in_mant[PW-3-MANT_W:0];
            s1_e_d    = $signed(in_exp) + $signed(EXP_W'(1));
        end else begin
            s1_kept_d = in_mant[PW-3 -: MANT_W];
            s1_g_d    = in_mant[PW-3-MANT_W];
            s1_s_d    = |in_mant[PW-4-MANT_W:0];
            s1_e_d    = $signed(in_exp);
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && s1_adv) begin
            s1_sign_q  <= in_sign;
            s1_class_q <= in_class;
            s1_kept_q  <= s1_kept_d;
            s1_g_q     <= s1_g_d;
            s1_s_q     <= s1_s_d;
            s1_e_q     <= s1_e_d;
        end
    end

    logic [MANT_W-1:0]   rnd_frac;
    logic [EXP_BITS-1:0] rnd_exp;
    logic                rnd_ovf, rnd_unf, rnd_inx;

    f_round_ne #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .EMAX   (2 * BIAS + 1)
    ) u_round (
        .kept_i    (s1_kept_q),
        .g_i       (s1_g_q),
        .s_i       (s1_s_q),
        .e_i       (s1_e_q),
        .frac_o    (rnd_frac),
        .exp_o     (rnd_exp),
        .ovf_o     (rnd_ovf),
        .unf_o     (rnd_unf),
        .inexact_o (rnd_inx)
    );

    always_comb begin
        out_d   = '0;
        flags_d = '0;
        case (s1_class_q)
            CLS_NORM: begin
                flags_d[FLAG_OVF] = rnd_ovf;
                flags_d[FLAG_UNF] = rnd_unf;
                flags_d[FLAG_INX] = rnd_inx;
                if (rnd_ovf)      out_d = {s1_sign_q, 8'hFF, {MANT_W{1'b0}}};
                else if (rnd_unf) out_d = {s1_sign_q, 31'h0};
                else              out_d = {s1_sign_q, rnd_exp, rnd_frac};
            end
            CLS_ZERO: out_d = {s1_sign_q, 31'h0};
            CLS_INF:  out_d = {s1_sign_q, 8'hFF, {MANT_W{1'b0}}};
            default:  out_d = QNAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (s2_adv) out_valid_q <= s1_valid_q;
            if (s2_adv && s1_valid_q) begin
                out_q   <= out_d;
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_f_mul_round_norm.sv
// Directed-vector bench: stimulus pushes hand-computed results into a queue,
// an independent monitor pops and compares on every output transfer.
module tb_f_mul_round_norm;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic [1:0]  in_class = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic [2:0]  out_flags;

    f_mul_round_norm dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_class  (in_class),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];
    string       name_q[$];

    localparam logic [1:0] NORM = 2'd0, ZERO = 2'd1, INF = 2'd2, NAN = 2'd3;

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [34:0] e;
        string       nm;
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h want none", {out, out_flags});
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, {out, out_flags}, e);
            end
        end
    end

    // Inputs change only #1 after posedge; in_ready sampled at the negedge
    // before the accepting edge.
    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic [1:0] c, input logic [34:0] want, input string nm);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_class = c;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(want);
                name_q.push_back(nm);
                @(posedge clk);
                #1;
                return;
            end
            if (i == 20) begin
                checks++;
                errors++;
                $display("FAIL send_timeout %s: got in_ready 0 want 1", nm);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(nm, 35'(exp_q.size()), 35'd0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {34'b0, out_valid}, 35'd0);
        chk("rst_out", {out, out_flags}, 35'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {34'b0, in_ready}, 35'd1);
        @(posedge clk);
        #1;

        // 1.5*1.5 with latency check
        send(1'b0, 10'd127, 48'h900000000000, NORM, {32'h40100000, 3'b000}, "mul_1p5sq");
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_c1", {34'b0, out_valid}, 35'd0);
        @(negedge clk);
        chk("latency_c2", {34'b0, out_valid}, 35'd1);
        @(posedge clk);
        #1;

        send(1'b0, 10'd127, 48'h400000400000, NORM, {32'h3F800000, 3'b001}, "tie_even_down");
        send(1'b0, 10'd127, 48'h400000C00000, NORM, {32'h3F800002, 3'b001}, "tie_even_up");
        send(1'b0, 10'd127, 48'h7FFFFFC00000, NORM, {32'h40000000, 3'b001}, "round_carry");
        send(1'b0, 10'd254, 48'h800000000000, NORM, {32'h7F800000, 3'b101}, "overflow");
        send(1'b1, 10'd0,   48'h400000000000, NORM, {32'h80000000, 3'b011}, "underflow");
        send(1'b1, 10'd5,   48'hFFFFFFFFFFFF, ZERO, {32'h80000000, 3'b000}, "cls_zero");
        send(1'b0, 10'd5,   48'h123456789ABC, INF,  {32'h7F800000, 3'b000}, "cls_inf");
        send(1'b1, 10'd5,   48'h123456789ABC, NAN,  {32'h7FC00000, 3'b000}, "cls_nan");
        send(1'b1, 10'd127, 48'h900000000000, NORM, {32'hC0100000, 3'b000}, "neg_1p5sq");
        send(1'b0, 10'd127, 48'h400000000000, NORM, {32'h3F800000, 3'b000}, "one");
        in_valid = 1'b0;
        drain("drain_stream");

        // Backpressure: 4 beats, out_ready low for 3 cycles
        out_ready = 1'b0;
        fork
            begin
                send(1'b0, 10'd127, 48'h400000000000, NORM, {32'h3F800000, 3'b000}, "bp_b1");
                send(1'b0, 10'd127, 48'h900000000000, NORM, {32'h40100000, 3'b000}, "bp_b2");
                send(1'b1, 10'd0,   48'h0,            ZERO, {32'h80000000, 3'b000}, "bp_b3");
                send(1'b0, 10'd0,   48'h0,            INF,  {32'h7F800000, 3'b000}, "bp_b4");
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", {34'b0, in_ready}, 35'd0);
                chk("bp_out_valid", {34'b0, out_valid}, 35'd1);
                chk("bp_hold_first", {out, out_flags}, {32'h3F800000, 3'b000});
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(1'b0, 10'd127, 48'h900000000000, NORM, {32'h40100000, 3'b000}, "rst_b1");
        send(1'b0, 10'd127, 48'h400000000000, NORM, {32'h3F800000, 3'b000}, "rst_b2");
        in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        name_q.delete();
        chk("midrst_out_valid", {34'b0, out_valid}, 35'd0);
        chk("midrst_out", {out, out_flags}, 35'd0);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {34'b0, in_ready}, 35'd1);
        repeat (10) @(posedge clk);
        #1;

        send(1'b0, 10'd127, 48'h900000000000, NORM, {32'h40100000, 3'b000}, "post_rst");
        in_valid = 1'b0;
        drain("drain_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
